// File: rtl/period_sequencer_pkg.sv
// Shared state encodings and constants for period_sequencer.
package period_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding queued periods; data storage is not reset.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot the same cycle, so a full FIFO still takes a write.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/period_sequencer.sv
// Feeds queued periods to a downstream strobe counter, one period per strobe.
// Build option PERIOD_SEQ_REPEAT_EN: repeat the last period when the queue is empty.
module period_sequencer
  import period_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_period,
  output logic             in_ready,
  input  logic             run,
  input  logic             cnt_ready,
  input  logic             cnt_strobe,
  output logic             cnt_enable,
  output logic [WIDTH-1:0] cnt_reset_value,
  output logic             period_done,
  output logic             busy,
  output logic             clamp_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             pop_load;
  logic             pop_strobe;
  logic [WIDTH-1:0] fifo_din;
  logic [WIDTH-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;

  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
    return (p < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : p;
  endfunction

  assign pop_load   = (state == LOAD);
  assign pop_strobe = (state == RUN) && cnt_strobe && !fifo_empty;
  assign fifo_pop   = pop_load || pop_strobe;
  assign in_ready   = !fifo_full || fifo_pop;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_din   = clamp_period(in_period);
  assign cnt_enable = (state == RUN) && run && cnt_ready && !cnt_strobe;
  assign busy       = (state != IDLE);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fifo_count != '0) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
        if (cnt_strobe && fifo_empty) begin
`ifdef PERIOD_SEQ_REPEAT_EN
          state_nxt = RUN;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt_reset_value <= WIDTH'(MIN_PERIOD);
      period_done     <= 1'b0;
      clamp_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      period_done <= cnt_strobe && (state == RUN);
      clamp_err   <= clamp_err | (fifo_push && (in_period < WIDTH'(MIN_PERIOD)));
      if (fifo_pop) cnt_reset_value <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_period_sequencer.sv
// Bench for period_sequencer with a simple strobe-counter model and a queue-based reference.
module tb_period_sequencer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_period;
  logic             in_ready;
  logic             run;
  logic             cnt_ready;
  logic             cnt_strobe;
  logic             cnt_enable;
  logic [WIDTH-1:0] cnt_reset_value;
  logic             period_done;
  logic             busy;
  logic             clamp_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int q[$];
  bit m_load, m_run, m_done, m_clamp;
  int m_rv;
  bit acc_last;
  int tick_cnt;
  int intervals[$];

  // downstream counter environment
  logic [WIDTH-1:0] c_cnt;

  period_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_period       (in_period),
    .in_ready        (in_ready),
    .run             (run),
    .cnt_ready       (cnt_ready),
    .cnt_strobe      (cnt_strobe),
    .cnt_enable      (cnt_enable),
    .cnt_reset_value (cnt_reset_value),
    .period_done     (period_done),
    .busy            (busy),
    .clamp_err       (clamp_err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_cnt      <= '0;
      cnt_strobe <= 1'b0;
    end else begin
      cnt_strobe <= 1'b0;
      if (cnt_enable) begin
        if (c_cnt + 1 >= cnt_reset_value) begin
          cnt_strobe <= 1'b1;
          c_cnt      <= '0;
        end else begin
          c_cnt <= c_cnt + 1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_load = 0; m_run = 0; m_done = 0; m_clamp = 0; m_rv = 2;
    tick_cnt = 0;
    intervals.delete();
  endtask

  task automatic reset_checks();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cnt_enable", cnt_enable, 0);
    check("rst_reset_value", cnt_reset_value, 2);
    check("rst_period_done", period_done, 0);
    check("rst_clamp_err", clamp_err, 0);
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst = 1;
    #2;
    reset_checks();
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic tick();
    bit pop, ex_ready, ex_en, nd, acc;
    int p;
    @(negedge clk);
    pop      = m_load || (m_run && cnt_strobe && q.size() > 0);
    ex_ready = (q.size() < DEPTH) || pop;
    ex_en    = m_run && run && cnt_ready && !cnt_strobe;
    check("cnt_enable", cnt_enable, ex_en);
    check("busy", busy, m_run || m_load);
    check("in_ready", in_ready, ex_ready);
    check("period_done", period_done, m_done);
    check("cnt_reset_value", cnt_reset_value, m_rv);
    check("clamp_err", clamp_err, m_clamp);
    if (cnt_enable) tick_cnt++;
    if (cnt_strobe) begin
      intervals.push_back(tick_cnt);
      tick_cnt = 0;
    end
    acc = in_valid && ex_ready;
    acc_last = acc;
    nd = cnt_strobe && m_run;
    if (m_load) begin
      m_rv = q.pop_front();
      m_load = 0;
      m_run = 1;
    end else if (m_run && cnt_strobe) begin
      if (q.size() > 0) m_rv = q.pop_front();
`ifndef PERIOD_SEQ_REPEAT_EN
      else m_run = 0;
`endif
    end else if (!m_run && q.size() > 0) begin
      m_load = 1;
    end
    if (acc) begin
      p = (in_period < 2) ? 2 : int'(in_period);
      q.push_back(p);
      if (in_period < 2) m_clamp = 1;
    end
    m_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int p);
    in_valid = 1;
    in_period = p;
    tick();
    in_valid = 0;
  endtask

  initial begin
    bit acc_seen;
    in_valid = 0; in_period = 0; run = 0; cnt_ready = 1;
    do_reset();

    // single period of 3
    write(3);
    run = 1;
    repeat (16) tick();
    check("t1_first_interval", intervals[0], 3);
`ifndef PERIOD_SEQ_REPEAT_EN
    check("t1_num_strobes", intervals.size(), 1);
    check("t1_busy_after", busy, 0);
`endif

    // back-to-back 4, 2, 5 with a stalling counter
    do_reset();
    run = 1;
    write(4); write(2); write(5);
    for (int i = 0; i < 80; i++) begin
      cnt_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cnt_ready = 1;
    check("t2_interval0", intervals[0], 4);
    check("t2_interval1", intervals[1], 2);
    check("t2_interval2", intervals[2], 5);
`ifndef PERIOD_SEQ_REPEAT_EN
    check("t2_num_strobes", intervals.size(), 3);
`endif

    // illegal periods are clamped and the flag sticks
    do_reset();
    run = 1;
    write(0); write(1);
    check("t3_clamp_err_set", clamp_err, 1);
    repeat (20) tick();
    check("t3_interval0", intervals[0], 2);
    check("t3_interval1", intervals[1], 2);
    check("t3_clamp_err_held", clamp_err, 1);

    // fill the FIFO, then write on the strobe-pop cycle
    do_reset();
    run = 0;
    write(7); write(8); write(9); write(10); write(11);
    check("t4_full_not_ready", in_ready, 0);
    check("t4_count_full", dut.u_fifo.count, 4);
    run = 1;
    in_valid = 1;
    in_period = 12;
    acc_seen = 0;
    for (int i = 0; i < 40 && !acc_seen; i++) begin
      tick();
      acc_seen = acc_last;
    end
    in_valid = 0;
    check("t4_write_accepted", acc_seen, 1);
    check("t4_count_stays", dut.u_fifo.count, 4);
    check("t4_reset_value_popped", cnt_reset_value, 8);
    tick();

    // reset in RUN with three periods queued
    for (int i = 0; i < 40 && q.size() != 3; i++) tick();
    check("t5_queued", dut.u_fifo.count, 3);
    check("t5_busy_before", busy, 1);
    do_reset();
    check("t5_fifo_empty", dut.u_fifo.count, 0);
    repeat (4) tick();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_period = $urandom_range(0, 9);
      run       = ($urandom_range(0, 4) != 0);
      cnt_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 0;

`ifdef PERIOD_SEQ_REPEAT_EN
    // one period repeated indefinitely
    do_reset();
    run = 1; cnt_ready = 1;
    write(6);
    repeat (50) tick();
    check("t7_enough_periods", intervals.size() >= 5, 1);
    for (int i = 0; i < intervals.size(); i++) check("t7_interval", intervals[i], 6);
    check("t7_busy_held", busy, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_sequencer.md
PERIOD_SEQUENCER -- requirements
Module: period_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: period/counter width; matches the downstream counter_with_strobe WIDTH.
REQ-002 SHALL have parameter DEPTH, default 4: period FIFO entries; power of two, >= 2.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  clock; rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have in_valid  input  1  period-write request.
REQ-005 SHALL have in_period  input  WIDTH  requested period, in enabled ticks per strobe.
REQ-006 SHALL have in_ready  output  1  FIFO can accept a write.
REQ-007 SHALL have run  input  1  global tick gate from the upstream pacing source.
REQ-008 SHALL have cnt_ready  input  1  counter ready output.
REQ-009 SHALL have cnt_strobe  input  1  counter strobe output.
REQ-010 SHALL have cnt_enable  output  1  counter enable.
REQ-011 SHALL have cnt_reset_value  output  WIDTH  counter reset_value.
REQ-012 SHALL have period_done  output  1  one-cycle pulse per completed period.
REQ-013 SHALL have busy  output  1  a period is active.
REQ-014 SHALL have clamp_err  output  1  sticky flag: an illegal period was clamped.

Function
REQ-015 SHALL accept a write on a clk edge when in_valid && in_ready; in_ready = FIFO not full.
REQ-016 SHALL clamp any accepted in_period < 2 to 2 before storing it, and SHALL set clamp_err, which stays high until rst.
REQ-017 SHALL implement the states IDLE, LOAD and RUN.
REQ-018 IDLE -> LOAD when the FIFO is non-empty; LOAD pops the head into cnt_reset_value and goes to RUN next cycle.
REQ-019 cnt_enable SHALL equal (state==RUN) && run && cnt_ready && !cnt_strobe; it is combinational with no added latency.
REQ-020 cnt_reset_value SHALL change only on an edge where cnt_strobe=1 and cnt_enable=0, or in LOAD from IDLE; it holds otherwise.
REQ-021 On cnt_strobe in RUN with the FIFO non-empty, the block SHALL pop the head into cnt_reset_value on that edge and stay in RUN.
REQ-022 On cnt_strobe in RUN with the FIFO empty, the block SHALL go to IDLE, or behave as in REQ-032 when configured.
REQ-023 period_done SHALL be cnt_strobe registered once, qualified by state==RUN; this gives 1-cycle latency.
REQ-024 busy SHALL be 1 in LOAD and RUN, and 0 in IDLE.
REQ-025 When a write and a pop occur in the same cycle with the FIFO full, the pop SHALL take effect first and the write SHALL be accepted (in_ready=1 that cycle).
REQ-026 When a write and a pop occur in the same cycle with the FIFO empty (IDLE), the written value SHALL NOT bypass the FIFO; it is loaded via LOAD on a later cycle.
REQ-027 Occupancy and pointer arithmetic SHALL be modulo DEPTH; the count is $clog2(DEPTH)+1 bits and never wraps past DEPTH.

Reset
REQ-028 On rst, the block SHALL asynchronously enter IDLE with the FIFO empty, in_ready=1, cnt_enable=0, cnt_reset_value=2, period_done=0, busy=0, clamp_err=0.
REQ-029 rst mid-period SHALL discard all queued periods; the counter is reset by the same rst net.
REQ-030 After rst deasserts, the block SHALL require at least one cycle in IDLE before LOAD.

Configuration
REQ-031 The feature macro SHALL be PERIOD_SEQ_REPEAT_EN.
REQ-032 With PERIOD_SEQ_REPEAT_EN defined, a strobe with the FIFO empty SHALL keep state RUN and cnt_reset_value unchanged, repeating the last period indefinitely.
REQ-033 Without PERIOD_SEQ_REPEAT_EN, REQ-022 SHALL apply: IDLE, busy=0, cnt_enable=0.

Structure
REQ-034 A shared include SHALL hold the state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2) and the constant MIN_PERIOD=2.
REQ-035 The FIFO SHALL be the sub-module sync_fifo (parameters WIDTH and DEPTH, with push, pop, full, empty and count).
REQ-036 The FSM, clamp and handshake logic SHALL stay in period_sequencer.

Verification
REQ-037 SHALL test: rst, write period 3, run=1, cnt_ready follows the counter -> period_done pulses every 3 enabled ticks, then busy=0 after the first strobe (macro off).
REQ-038 SHALL test: write periods 4, 2, 5 back-to-back -> strobes at 4, 2 and 5 enabled-tick intervals; cnt_reset_value changes only in strobe cycles where cnt_enable=0.
REQ-039 SHALL test: write period 0 or 1 -> stored as 2; clamp_err=1 and held until rst.
REQ-040 SHALL test: fill DEPTH=4 with the FIFO full, then write on a strobe-pop cycle -> write accepted, count stays 4.
REQ-041 SHALL test: assert rst during RUN with 3 queued periods -> next cycle IDLE, FIFO empty, cnt_enable=0, cnt_reset_value=2.
REQ-042 SHALL test: with PERIOD_SEQ_REPEAT_EN defined, write period 6 once -> period_done every 6 enabled ticks for at least 5 periods, busy held at 1.
